bsg_tag_serial_client: RTL and testbench
========================================

Name: bsg_tag_serial_client

Overview:
- ASIC-side receive end of the two-wire tag link (tdi/tms) driven by the gateway tag master.
- Deserializes packets from the link, filters them by node ID, and delivers either a payload word or a client-reset pulse to local logic.
- One instance per tag node. All logic runs in the tag clock domain; tdi/tms are sampled on every rising clk_i edge.

Parameters:
- node_id_p, 0: ID this client answers to.
- id_width_p, 4: width of the ID field.
- len_width_p, 5: width of the length field.
- payload_width_p, 16: width of data_o.

Ports:
- clk_i  in  1  tag clock.
- reset_i  in  1  synchronous, active-high reset.
- tdi_i  in  1  serial data.
- tms_i  in  1  abort/resync strobe; 1 = abort the current packet.
- data_o  out  payload_width_p  last accepted payload.
- data_v_o  out  1  one-cycle pulse; data_o was updated this cycle.
- client_reset_o  out  1  one-cycle pulse; reset packet received.
- busy_o  out  1  a packet is in progress (FSM not in IDLE).
- overflow_o  out  1  sticky; a matched data packet had len > payload_width_p.

Behaviour:
- Interface: one clock, clk_i; synchronous active-high reset, reset_i.
- Packet format (all fields LSB first, one bit per cycle):
  - start bit = 1
  - id[id_width_p]
  - dnr[1]: 1 = data packet, 0 = reset packet
  - len[len_width_p]
  - len payload bits
- Packet duration is 2 + id_width_p + len_width_p + len cycles.
- Reset: FSM goes to IDLE. data_o = 0, data_v_o = 0, client_reset_o = 0, busy_o = 0, overflow_o = 0. Counters and shift registers are cleared.
- FSM states: IDLE, ID, DNR, LEN, PAY.
  - IDLE: tdi_i = 0 stays in IDLE; tdi_i = 1 goes to ID.
  - ID: shifts in id_width_p bits, then goes to DNR.
  - DNR: latches dnr, goes to LEN.
  - LEN: shifts in len_width_p bits. If len = 0, the packet completes and the FSM goes to IDLE. Otherwise it goes to PAY.
  - PAY: counts len bits, then goes to IDLE.
- Bit capture: payload bit k (k < payload_width_p) is stored at bit position k of a staging register, which is cleared at packet start. Bits with k >= payload_width_p are consumed and discarded.
- Completion: on the cycle after the last bit is sampled (cycle N+1):
  - Matched data packet: data_o <= staging register, with bits at positions >= len equal to 0. data_v_o = 1 for exactly one cycle. If len > payload_width_p, overflow_o <= 1 and stays 1 until reset_i.
  - Matched reset packet: client_reset_o = 1 for one cycle and data_o <= 0. The payload is consumed but ignored, and overflow_o is unaffected.
  - Non-matching ID: full packet consumed. No pulses, data_o unchanged, overflow_o unchanged.
- busy_o is 1 from the cycle after the start bit through the cycle the last bit is sampled.
- Back-to-back packets: the FSM is in IDLE in cycle N+1, so a start bit sampled in N+1 is accepted. Zero gap is legal, and the output pulses of the previous packet coexist with the new start.
- Abort: tms_i = 1 in any cycle forces IDLE in the next cycle.
  - tdi_i is ignored that cycle, even if it is 1.
  - The partial packet is discarded with no pulses; data_o and overflow_o are held.
  - An abort in the same cycle the last bit arrives cancels completion.
- reset_i has priority over tms_i and over completion. A reset mid-packet drops the packet and emits no pulse.
- data_v_o and client_reset_o are never high in the same cycle.

Test Plan (node_id_p=3, id_width_p=4, len_width_p=5, payload_width_p=16):
1. Data packet, id=3, dnr=1, len=8, payload=0xA5 (19 bits total) -> busy_o high 18 cycles; one cycle after the last bit, data_v_o=1 and data_o=0x00A5; overflow_o=0.
2. Same packet with id=5 -> no data_v_o or client_reset_o pulse; data_o stays 0x00A5; busy_o behaves as in scenario 1.
3. Reset packet, id=3, dnr=0, len=0 (11 bits) -> client_reset_o pulses one cycle after the last bit; data_o=0x0000; data_v_o stays 0.
4. Data packet, id=3, len=20, payload=0xFBEEF (LSB first) -> data_o=0xBEEF with one data_v_o pulse; overflow_o=1 and stays 1 through a following normal packet until reset_i.
5. tms_i=1 at payload bit 3 of an id=3 packet, then a clean id=3 len=4 payload=0x9 packet -> no pulse from the first packet; the second gives data_o=0x0009 with one data_v_o pulse.
6. Two id=3 data packets with zero gap (0x12 then 0x34, len=8) -> two data_v_o pulses 19 cycles apart with data_o=0x0012 then 0x0034. Repeat with reset_i asserted mid-payload of the first packet -> first packet dropped, all outputs 0 during and after reset, second packet received normally if it starts after reset deasserts.

Source files
------------

// File: rtl/bsg_tag_serial_client.sv
// Receive end of the two-wire tag link: deserializes start/id/dnr/len/payload
// packets, filters them by node ID and emits a payload word or a client-reset pulse.
`timescale 1ns/1ps
module bsg_tag_serial_client #(
    parameter int node_id_p       = 0,
    parameter int id_width_p      = 4,
    parameter int len_width_p     = 5,
    parameter int payload_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tdi_i,
    input  logic                       tms_i,
    output logic [payload_width_p-1:0] data_o,
    output logic                       data_v_o,
    output logic                       client_reset_o,
    output logic                       busy_o,
    output logic                       overflow_o
);

    // One counter serves the id, len and payload phases, so it must hold the largest of them.
    localparam int max_field_lp = (id_width_p > len_width_p) ? id_width_p : len_width_p;
    localparam int pay_idx_lp   = $clog2(payload_width_p + 1);
    localparam int cnt_w_lp     = ((max_field_lp > pay_idx_lp) ? max_field_lp : pay_idx_lp) + 1;

    typedef enum logic [2:0] {IDLE, ID, DNR, LEN, PAY} state_e;

    state_e                     state_r;
    logic [cnt_w_lp-1:0]        cnt_r;
    logic [id_width_p-1:0]      id_r;
    logic                       dnr_r;
    logic [len_width_p-1:0]     len_r;
    logic [payload_width_p-1:0] stage_r;

    logic [len_width_p-1:0]     len_next;
    logic [payload_width_p-1:0] stage_next;
    logic                       id_match;
    logic                       len_last;
    logic                       pay_last;
    logic                       last_bit;
    logic                       too_long;

    assign len_next = {tdi_i, len_r[len_width_p-1:1]};
    assign id_match = (id_r == id_width_p'(node_id_p));
    assign len_last = (state_r == LEN) && (cnt_r == cnt_w_lp'(len_width_p - 1));
    assign pay_last = (state_r == PAY) && (cnt_r == cnt_w_lp'(len_r) - cnt_w_lp'(1));
    assign last_bit = (len_last && (len_next == '0)) || pay_last;
    assign too_long = (state_r == PAY) && (32'(len_r) > payload_width_p);
    assign busy_o   = (state_r != IDLE);

    // Payload bit k lands at position k; bits beyond the register width are dropped.
    always_comb begin
        stage_next = stage_r;
        for (int i = 0; i < payload_width_p; i++) begin
            if ((state_r == PAY) && (cnt_r == cnt_w_lp'(i))) begin
                stage_next[i] = tdi_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            id_r           <= '0;
            dnr_r          <= 1'b0;
            len_r          <= '0;
            stage_r        <= '0;
            data_o         <= '0;
            data_v_o       <= 1'b0;
            client_reset_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            data_v_o       <= 1'b0;
            client_reset_o <= 1'b0;
            if (tms_i) begin
                state_r <= IDLE;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (tdi_i) begin
                            state_r <= ID;
                            cnt_r   <= '0;
                            stage_r <= '0;
                        end
                    end
                    ID: begin
                        id_r <= {tdi_i, id_r[id_width_p-1:1]};
                        if (cnt_r == cnt_w_lp'(id_width_p - 1)) begin
                            cnt_r   <= '0;
                            state_r <= DNR;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    DNR: begin
                        dnr_r   <= tdi_i;
                        state_r <= LEN;
                    end
                    LEN: begin
                        len_r <= len_next;
                        if (len_last) begin
                            cnt_r   <= '0;
                            state_r <= (len_next == '0) ? IDLE : PAY;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    PAY: begin
                        stage_r <= stage_next;
                        if (pay_last) begin
                            cnt_r   <= '0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + cnt_w_lp'(1);
                        end
                    end
                    default: state_r <= IDLE;
                endcase

                // A zero-length packet completes from LEN, where the staging register is still clear.
                if (last_bit && id_match) begin
                    if (dnr_r) begin
                        data_o   <= stage_next;
                        data_v_o <= 1'b1;
                        if (too_long) begin
                            overflow_o <= 1'b1;
                        end
                    end else begin
                        data_o         <= '0;
                        client_reset_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_tag_serial_client.sv
// Self-checking bench for bsg_tag_serial_client: packets are described at field level
// and a packet-level model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_bsg_tag_serial_client;

    localparam int node_lp = 3;
    localparam int pw_lp   = 16;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        tdi_i = 1'b0;
    logic        tms_i = 1'b0;
    logic [15:0] data_o;
    logic        data_v_o;
    logic        client_reset_o;
    logic        busy_o;
    logic        overflow_o;

    bsg_tag_serial_client #(
        .node_id_p(node_lp),
        .id_width_p(4),
        .len_width_p(5),
        .payload_width_p(pw_lp)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .tdi_i(tdi_i),
        .tms_i(tms_i),
        .data_o(data_o),
        .data_v_o(data_v_o),
        .client_reset_o(client_reset_o),
        .busy_o(busy_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Per-cycle stimulus and expected/observed vectors {data_v, client_reset, busy, overflow, data}.
    logic        tdi_q[$];
    logic        tms_q[$];
    logic        rst_q[$];
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    logic [15:0] m_data = '0;
    logic        m_ovf = 1'b0;

    function automatic logic [19:0] exp_vec(input logic dv, input logic cr, input logic busy);
        return {dv, cr, busy, m_ovf, m_data};
    endfunction

    task automatic clear_queues();
        tdi_q.delete();
        tms_q.delete();
        rst_q.delete();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push(input logic d, input logic t, input logic r, input logic [19:0] e);
        tdi_q.push_back(d);
        tms_q.push_back(t);
        rst_q.push_back(r);
        exp_q.push_back(e);
    endtask

    task automatic add_idle(input int n);
        repeat (n) push(1'b0, 1'b0, 1'b0, exp_vec(1'b0, 1'b0, 1'b0));
    endtask

    task automatic add_reset(input int n);
        m_data = '0;
        m_ovf  = 1'b0;
        repeat (n) push(1'($urandom_range(0, 1)), 1'b0, 1'b1, exp_vec(1'b0, 1'b0, 1'b0));
    endtask

    // cut_kind: 0 = complete packet, 1 = tms abort at bit cut_at, 2 = reset_i at bit cut_at.
    task automatic add_packet(input int id, input int dnr, input int len, input logic [31:0] payload,
                              input int cut_at = -1, input int cut_kind = 0);
        logic        bits[$];
        logic [31:0] mask;
        int          n_bits;
        bits.push_back(1'b1);
        for (int i = 0; i < 4; i++) bits.push_back(id[i]);
        bits.push_back(dnr[0]);
        for (int i = 0; i < 5; i++) bits.push_back(len[i]);
        for (int k = 0; k < len; k++) bits.push_back(payload[k]);
        n_bits = bits.size();
        for (int j = 0; j < n_bits; j++) begin
            if (cut_kind != 0 && j == cut_at) begin
                if (cut_kind == 1) push(bits[j], 1'b1, 1'b0, exp_vec(1'b0, 1'b0, 1'b0));
                else add_reset(2);
                return;
            end
            if (j < n_bits - 1) begin
                push(bits[j], 1'b0, 1'b0, exp_vec(1'b0, 1'b0, 1'b1));
            end else if (id != node_lp) begin
                push(bits[j], 1'b0, 1'b0, exp_vec(1'b0, 1'b0, 1'b0));
            end else if (dnr != 0) begin
                mask   = (32'd1 << len) - 32'd1;
                m_data = 16'(payload & mask);
                if (len > pw_lp) m_ovf = 1'b1;
                push(bits[j], 1'b0, 1'b0, exp_vec(1'b1, 1'b0, 1'b0));
            end else begin
                m_data = '0;
                push(bits[j], 1'b0, 1'b0, exp_vec(1'b0, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic run_stream();
        for (int i = 0; i < tdi_q.size(); i++) begin
            @(negedge clk_i);
            tdi_i   = tdi_q[i];
            tms_i   = tms_q[i];
            reset_i = rst_q[i];
            @(posedge clk_i);
            #1;
            obs_q.push_back({data_v_o, client_reset_o, busy_o, overflow_o, data_o});
        end
        @(negedge clk_i);
        tdi_i   = 1'b0;
        tms_i   = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_queues();
        add_reset(3);
        add_idle(3);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL reset cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_data_packet();
        int busy_cycles;
        clear_queues();
        add_packet(3, 1, 8, 32'hA5);
        add_idle(3);
        run_stream();
        busy_cycles = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i][17] === 1'b1) busy_cycles++;
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL data_packet cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
        checks++;
        if (busy_cycles !== 18) begin
            failures++;
            $display("[TB] FAIL busy_length: got %0d busy cycles, expected 18", busy_cycles);
        end
    endtask

    task automatic test_id_filter();
        clear_queues();
        add_packet(5, 1, 8, 32'hA5);
        add_packet(9, 0, 0, 32'h0);
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL id_filter cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_reset_packet();
        clear_queues();
        add_packet(3, 0, 0, 32'h0);
        add_idle(2);
        add_packet(3, 1, 3, 32'h5);
        add_packet(3, 0, 6, 32'h3F);
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL reset_packet cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_queues();
        add_packet(3, 1, 20, 32'hFBEEF);
        add_idle(1);
        add_packet(3, 1, 8, 32'h5A);
        add_packet(3, 0, 2, 32'h3);
        add_idle(2);
        add_reset(2);
        add_idle(2);
        add_packet(3, 1, 16, 32'hC3C3);
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL overflow cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_abort();
        clear_queues();
        add_packet(3, 1, 8, 32'h77, 11 + 3, 1);
        add_packet(3, 1, 4, 32'h9);
        add_idle(1);
        add_packet(3, 1, 4, 32'h6, 14, 1);
        add_idle(1);
        add_packet(3, 1, 4, 32'hF, 0, 1);
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL abort cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulse_at[$];
        clear_queues();
        add_packet(3, 1, 8, 32'h12);
        add_packet(3, 1, 8, 32'h34);
        add_idle(2);
        add_packet(3, 1, 8, 32'h12, 11 + 4, 2);
        add_packet(3, 1, 8, 32'h34);
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (obs_q[i][19] === 1'b1) pulse_at.push_back(i);
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL back_to_back cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
        checks++;
        if (pulse_at.size() < 2 || (pulse_at[1] - pulse_at[0]) !== 19) begin
            failures++;
            $display("[TB] FAIL pulse_spacing: got %0d pulses, first gap %0d, expected gap 19",
                     pulse_at.size(), (pulse_at.size() < 2) ? -1 : pulse_at[1] - pulse_at[0]);
        end
    endtask

    task automatic test_random();
        int id, dnr, len, kind, cut;
        clear_queues();
        for (int p = 0; p < 40; p++) begin
            id   = ($urandom_range(0, 1) == 1) ? node_lp : int'($urandom_range(0, 15));
            dnr  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            len  = $urandom_range(0, 24);
            kind = $urandom_range(0, 15);
            cut  = $urandom_range(0, 10 + len);
            if (kind < 2) add_packet(id, dnr, len, $urandom, cut, 1);
            else if (kind == 2) add_packet(id, dnr, len, $urandom, cut, 2);
            else add_packet(id, dnr, len, $urandom);
            add_idle($urandom_range(0, 2));
        end
        add_idle(2);
        run_stream();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL random cycle %0d: got dv,cr,busy,ovf=%b data=%h, expected dv,cr,busy,ovf=%b data=%h",
                         i, obs_q[i][19:16], obs_q[i][15:0], exp_q[i][19:16], exp_q[i][15:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_data_packet();
        test_id_filter();
        test_reset_packet();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
